// File: rtl/tcore_regfile_sb.sv
// rtl/tcore_regfile_sb.sv - integer register file with write-through bypass and pending-write scoreboard
module tcore_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int PEND_W = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rf_rw_en_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            trap_active_i,
    input  logic            flush_i,
    input  logic            issue_en_i,
    input  logic [AW-1:0]   issue_rd_i,
    output logic            issue_block_o,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            sb_err_o,
    output logic [63:0]     retire_cnt_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   regs [NREG];
    logic [PEND_W-1:0] pend [NREG];
    logic              sb_err;
    logic [63:0]       retire_cnt;
    logic              sb_clear;

    assign sb_clear     = trap_active_i || flush_i;
    assign sb_err_o     = sb_err;
    assign retire_cnt_o = retire_cnt;

    // A saturated rd can still book if its own retire frees a slot this cycle.
    assign issue_block_o = issue_en_i && (issue_rd_i != '0) && !sb_clear
                        && (pend[issue_rd_i] == PEND_MAX)
                        && !(rf_rw_en_i && (wb_rd_i == issue_rd_i));

    always_comb begin
        rs1_data_o = regs[rs1_addr_i];
        rs2_data_o = regs[rs2_addr_i];
        if (rf_rw_en_i && (wb_rd_i == rs1_addr_i)) rs1_data_o = wb_data_i;
        if (rf_rw_en_i && (wb_rd_i == rs2_addr_i)) rs2_data_o = wb_data_i;
        if (rs1_addr_i == '0) rs1_data_o = '0;
        if (rs2_addr_i == '0) rs2_data_o = '0;
    end

    // The last outstanding write retiring now is covered by the bypass path.
    assign rs1_busy_o = (pend[rs1_addr_i] != '0)
                     && !(rf_rw_en_i && (wb_rd_i == rs1_addr_i) && (pend[rs1_addr_i] == PEND_W'(1)));
    assign rs2_busy_o = (pend[rs2_addr_i] != '0)
                     && !(rf_rw_en_i && (wb_rd_i == rs2_addr_i) && (pend[rs2_addr_i] == PEND_W'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            sb_err     <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (rf_rw_en_i) retire_cnt <= retire_cnt + 64'd1;
            if (rf_rw_en_i && (wb_rd_i != '0)) begin
                regs[wb_rd_i] <= wb_data_i;
                if (pend[wb_rd_i] == '0) sb_err <= 1'b1;
            end
            for (int i = 1; i < NREG; i++) begin
                if (sb_clear) begin
                    pend[i] <= '0;
                end else begin
                    logic inc, dec;
                    inc = issue_en_i && (issue_rd_i == AW'(i)) && !issue_block_o;
                    dec = rf_rw_en_i && (wb_rd_i == AW'(i)) && (pend[i] != '0);
                    if (inc && !dec)      pend[i] <= pend[i] + PEND_W'(1);
                    else if (dec && !inc) pend[i] <= pend[i] - PEND_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tcore_regfile_sb.sv
// tb/tb_tcore_regfile_sb.sv - self-checking bench for tcore_regfile_sb against a behavioural model
module tb_tcore_regfile_sb;

    localparam int PMAX = 3;

    logic        clk, rst_n;
    logic        we, trap, flush, ie, block;
    logic [4:0]  wrd, ird, rs1, rs2;
    logic [31:0] wdata, d1, d2;
    logic        b1, b2, err;
    logic [63:0] cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic        m_err;
    logic [63:0] m_cnt;

    tcore_regfile_sb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rf_rw_en_i(we), .wb_rd_i(wrd), .wb_data_i(wdata),
        .trap_active_i(trap), .flush_i(flush),
        .issue_en_i(ie), .issue_rd_i(ird), .issue_block_o(block),
        .rs1_addr_i(rs1), .rs2_addr_i(rs2),
        .rs1_data_o(d1), .rs2_data_o(d2),
        .rs1_busy_o(b1), .rs2_busy_o(b2),
        .sb_err_o(err), .retire_cnt_o(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we && wrd == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        return (m_pend[a] != 0) && !(we && wrd == a && m_pend[a] == 1);
    endfunction

    function automatic logic m_block();
        return ie && ird != 5'd0 && m_pend[ird] == PMAX && !(we && wrd == ird) && !(trap || flush);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
        m_cnt = 64'd0;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            logic blk, rok;
            blk = m_block();
            rok = we && wrd != 5'd0 && m_pend[wrd] != 0;
            if (we) m_cnt = m_cnt + 64'd1;
            if (we && wrd != 5'd0) begin
                if (m_pend[wrd] == 0) m_err = 1'b1;
                m_regs[wrd] = wdata;
            end
            if (trap || flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 0;
            end else begin
                if (ie && ird != 5'd0 && !blk) m_pend[ird] = m_pend[ird] + 1;
                if (rok) m_pend[wrd] = m_pend[wrd] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rs1_data", {32'd0, d1}, {32'd0, m_read(rs1)});
            chk("rs2_data", {32'd0, d2}, {32'd0, m_read(rs2)});
            chk("rs1_busy", {63'd0, b1}, {63'd0, m_busy(rs1)});
            chk("rs2_busy", {63'd0, b2}, {63'd0, m_busy(rs2)});
            chk("issue_block", {63'd0, block}, {63'd0, m_block()});
            chk("sb_err", {63'd0, err}, {63'd0, m_err});
            chk("retire_cnt", cnt, m_cnt);
        end
    end

    task automatic idle();
        we = 0; wrd = 0; wdata = 0; trap = 0; flush = 0; ie = 0; ird = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        step();
        step();
        #1 rst_n = 1'b1;
        step();
    endtask

    initial begin
        idle();
        rs1 = 0; rs2 = 0;
        rst_n = 1'b0;
        m_reset();
        #12;
        chk("reset_rs1_data", {32'd0, d1}, 64'd0);
        chk("reset_busy", {62'd0, b1, b2}, 64'd0);
        chk("reset_block", {63'd0, block}, 64'd0);
        chk("reset_sb_err", {63'd0, err}, 64'd0);
        chk("reset_retire_cnt", cnt, 64'd0);
        step();
        #1 rst_n = 1'b1;
        step();

        // bypass then array read of x5
        we = 1; wrd = 5; wdata = 32'hDEADBEEF; rs1 = 5;
        peek();
        chk("x5_bypass", {32'd0, d1}, 64'hDEADBEEF);
        step();
        idle();
        peek();
        chk("x5_array", {32'd0, d1}, 64'hDEADBEEF);
        chk("retire_after_x5", cnt, 64'd1);

        // x0 write discarded but counted
        we = 1; wrd = 0; wdata = 32'h1234; rs2 = 0;
        peek();
        chk("x0_same_cycle", {32'd0, d2}, 64'd0);
        step();
        idle();
        peek();
        chk("x0_after", {32'd0, d2}, 64'd0);
        chk("retire_after_x0", cnt, 64'd2);
        step();

        do_reset();

        // saturate x7
        ie = 1; ird = 7; rs1 = 7;
        peek();
        chk("x7_not_busy_yet", {63'd0, b1}, 64'd0);
        step(); step(); step();
        peek();
        chk("x7_busy_pend3", {63'd0, b1}, 64'd1);
        chk("x7_fourth_blocked", {63'd0, block}, 64'd1);
        step();
        ie = 0; ird = 0;
        for (int k = 0; k < 3; k++) begin
            we = 1; wrd = 7; wdata = 32'h70 + k;
            peek();
            chk("x7_busy_during_retire", {63'd0, b1}, (k == 2) ? 64'd0 : 64'd1);
            chk("x7_bypass", {32'd0, d1}, 64'h70 + k);
            step();
        end
        idle();
        peek();
        chk("x7_free", {63'd0, b1}, 64'd0);
        chk("x7_value", {32'd0, d1}, 64'h72);
        chk("x7_no_err", {63'd0, err}, 64'd0);

        // issue and retire x9 in the same cycle
        ie = 1; ird = 9; rs2 = 9;
        step();
        we = 1; wrd = 9; wdata = 32'h90;
        peek();
        chk("x9_issue_retire_no_block", {63'd0, block}, 64'd0);
        step();
        idle();
        peek();
        chk("x9_still_pend", {63'd0, b2}, 64'd1);
        step();
        we = 1; wrd = 9; wdata = 32'h91;
        step();
        idle();
        peek();
        chk("x9_done", {63'd0, b2}, 64'd0);
        chk("x9_value", {32'd0, d2}, 64'h91);
        chk("x9_no_err", {63'd0, err}, 64'd0);
        step();

        do_reset();

        // flush forces block low and clears bookings
        ie = 1; ird = 6; rs1 = 6;
        step(); step(); step();
        flush = 1;
        peek();
        chk("flush_block_forced0", {63'd0, block}, 64'd0);
        step();
        idle();
        peek();
        chk("x6_cleared", {63'd0, b1}, 64'd0);

        // trap with same-cycle writeback
        ie = 1; ird = 3;
        step(); step();
        ird = 4;
        step();
        idle();
        trap = 1; we = 1; wrd = 3; wdata = 32'h55;
        step();
        idle();
        rs1 = 3; rs2 = 4;
        peek();
        chk("trap_x3_free", {63'd0, b1}, 64'd0);
        chk("trap_x4_free", {63'd0, b2}, 64'd0);
        chk("trap_x3_value", {32'd0, d1}, 64'h55);
        chk("trap_no_err", {63'd0, err}, 64'd0);
        step();

        // underflow on x10, sticky error
        we = 1; wrd = 10; wdata = 32'hA5A5A5A5;
        step();
        idle();
        step(); step();
        rs1 = 10;
        peek();
        chk("x10_value", {32'd0, d1}, 64'hA5A5A5A5);
        chk("sb_err_sticky", {63'd0, err}, 64'd1);
        ie = 1; ird = 11; rs2 = 11;
        step();
        idle();
        peek();
        chk("x11_busy", {63'd0, b2}, 64'd1);

        // asynchronous reset mid-run
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_rs1_data", {32'd0, d1}, 64'd0);
        chk("async_rst_busy", {63'd0, b2}, 64'd0);
        chk("async_rst_sb_err", {63'd0, err}, 64'd0);
        chk("async_rst_retire_cnt", cnt, 64'd0);
        step();
        #1 rst_n = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
